// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues credit-limited fetches and queues {pc, instr} pairs in order.
// Optional macro FETCH_BUFFER_BYPASS_EN lets a response reach InstrF in its arrival cycle when the FIFO is empty.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        StallF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        instr_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_last_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_req_fire;
  logic          w_rsp_keep;
  logic          w_drop;
  logic          w_fifo_nempty;
  logic          w_fifo_pop;
  logic          w_head_pop;
  logic          w_push;
  logic          w_bypass;
  logic [CW-1:0] w_outst_next;

  // Credit: entries held plus requests in flight never exceed DEPTH, so a push always finds room.
  assign w_inflight     = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !reset && !redirect && (w_inflight < (CW+1)'(DEPTH));
  assign imem_addr      = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_keep    = imem_rsp_valid && !redirect && (r_drop_cnt == '0);
  assign w_drop        = imem_rsp_valid && !redirect && (r_drop_cnt != '0);
  assign w_fifo_nempty = (r_count != '0);
  assign w_fifo_pop    = w_fifo_nempty && !StallF && !redirect;
  assign w_outst_next  = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_bypass = w_rsp_keep && !w_fifo_nempty;
  assign w_push   = w_rsp_keep && (w_fifo_nempty || StallF);
`else
  assign w_bypass = 1'b0;
  assign w_push   = w_rsp_keep;
`endif

  assign instr_valid = !reset && (w_fifo_nempty || w_bypass);
  assign w_head_pop  = instr_valid && !StallF && !redirect;

  always_comb begin
    InstrF = 32'h0;
    PCF    = r_last_pc;
    if (reset) begin
      PCF = RESET_PC;
    end else if (w_fifo_nempty) begin
      InstrF = r_instr_mem[r_rd_ptr];
      PCF    = r_pc_mem[r_rd_ptr];
    end else if (w_bypass) begin
      InstrF = imem_rdata;
      PCF    = r_rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_last_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= w_outst_next;
      if (redirect) begin
        // The response landing this cycle is already gone, so only the remainder is dropped.
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_drop_cnt <= w_outst_next;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop)     r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + 32'd4;
        if (w_push)     r_wr_ptr   <= r_wr_ptr + AW'(1);
        if (w_fifo_pop) r_rd_ptr   <= r_rd_ptr + AW'(1);
        if (w_head_pop) r_last_pc  <= PCF;
        r_count <= r_count + CW'(w_push) - CW'(w_fifo_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_pc_mem[r_wr_ptr]    <= r_rsp_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == CW'(DEPTH))));

endmodule
